uart_tx_ram: RTL and testbench

//  - UART transmitter that plays back the receive-side RAM over a serial Tx line.
//  - On a start request it reads NUM_BYTES entries from the 8-deep byte RAM, beginning at START_ADDR.
//  - It sends each entry as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
//  - It sits beside the receiver/RAM pair in main and drives the RAM read port (read address, read enable).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_bit.sv | 54 +++++
 rtl/uart_tx_ram.sv | 96 +++++++++
 tb/tb_uart_tx_ram.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the RAM-playback UART transmit path.
package uart_pkg;
   localparam int unsigned UART_DATA_BITS       = 8;
   localparam int unsigned RAM_ADDR_W           = 3;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;
   localparam int unsigned FRAME_BITS           = UART_DATA_BITS + 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      LOAD      = 3'd2,
      START_BIT = 3'd3,
      DATA_BITS = 3'd4,
      STOP_BIT  = 3'd5,
      NEXT      = 3'd6
   } tx_state_t;
endpackage

// File: rtl/uart_tx_bit.sv
// Baud counter and 10-bit 8N1 frame shifter; tx is registered from the shifter LSB.
module uart_tx_bit
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [UART_DATA_BITS-1:0] data_in,
   output logic                      tx,
   output logic                      bit_tick,
   output logic                      frame_done
);
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

   logic [CNT_W-1:0]      baud_cnt;
   logic [3:0]            bit_cnt;
   logic [FRAME_BITS-1:0] frame;
   logic                  active;

   assign bit_tick   = active && (baud_cnt == CNT_LAST);
   assign frame_done = bit_tick && (bit_cnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         frame    <= '1;
         active   <= 1'b0;
         tx       <= 1'b1;
      end else begin
         // Shifter refills with ones, so tx idles high once the stop bit has gone out.
         tx <= frame[0];
         if (load) begin
            frame    <= {1'b1, data_in, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b1;
         end else if (bit_tick) begin
            frame    <= {1'b1, frame[FRAME_BITS-1:1]};
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == BIT_LAST) begin
               active <= 1'b0;
            end
         end else if (active) begin
            baud_cnt <= baud_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/uart_tx_ram.sv
// UART transmitter that plays a burst of bytes out of the receive-side RAM as 8N1 frames.
module uart_tx_ram
   import uart_pkg::*;
#(
   parameter int unsigned           CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned           NUM_BYTES    = 8,
   parameter logic [RAM_ADDR_W-1:0] START_ADDR   = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [UART_DATA_BITS-1:0] ram_rdata,
   output logic [RAM_ADDR_W-1:0]     ram_raddr,
   output logic                      ram_re,
   output logic                      tx,
   output logic                      busy,
   output logic                      done
);
   localparam logic [RAM_ADDR_W-1:0] LAST_CNT = RAM_ADDR_W'(NUM_BYTES - 1);

   tx_state_t             state, state_nxt;
   logic [RAM_ADDR_W-1:0] byte_cnt;
   logic [2:0]            bit_idx;
   logic                  last_byte;
   logic                  bit_tick;
   logic                  frame_done;

   assign last_byte = (byte_cnt == LAST_CNT);

   uart_tx_bit #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_bit (
      .clk       (clk),
      .rst       (rst),
      .load      (state == LOAD),
      .data_in   (ram_rdata),
      .tx        (tx),
      .bit_tick  (bit_tick),
      .frame_done(frame_done)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start) state_nxt = FETCH;
         FETCH:     state_nxt = LOAD;
         LOAD:      state_nxt = START_BIT;
         START_BIT: if (bit_tick) state_nxt = DATA_BITS;
         DATA_BITS: if (bit_tick && (bit_idx == 3'd7)) state_nxt = STOP_BIT;
         STOP_BIT:  if (frame_done) state_nxt = NEXT;
         NEXT:      state_nxt = last_byte ? IDLE : FETCH;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ram_raddr <= START_ADDR;
         ram_re    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         byte_cnt  <= '0;
         bit_idx   <= '0;
      end else begin
         state <= state_nxt;
         // Strobe is registered from the next state so the RAM sees it while in FETCH.
         ram_re <= (state_nxt == FETCH);
         done   <= (state == NEXT) && last_byte;
         case (state)
            IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  byte_cnt  <= '0;
                  ram_raddr <= START_ADDR;
               end
            end
            START_BIT: begin
               if (bit_tick) bit_idx <= '0;
            end
            DATA_BITS: begin
               if (bit_tick && (bit_idx != 3'd7)) bit_idx <= bit_idx + 3'd1;
            end
            NEXT: begin
               if (last_byte) begin
                  busy <= 1'b0;
               end else begin
                  byte_cnt  <= byte_cnt + RAM_ADDR_W'(1);
                  ram_raddr <= ram_raddr + RAM_ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_ram.sv
// Scoreboard bench: three DUT configurations share a clock; a monitor decodes tx frames per DUT.
module tb_uart_tx_ram;
   localparam int unsigned CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start, ram_re, tx, busy, done;
   logic [2:0] raddr [3];
   logic [7:0] rdata [3];
   logic [7:0] mem   [3][8];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // monitor state and observations, per DUT
   bit         in_frame [3] = '{0, 0, 0};
   int         off      [3] = '{0, 0, 0};
   int         ones     [3] = '{99, 99, 99};
   logic [7:0] sh       [3];
   logic       stopv    [3];
   int         done_cnt [3] = '{0, 0, 0};
   logic [7:0] obs_byte [3][$];
   logic       obs_stop [3][$];
   logic [2:0] obs_addr [3][$];
   int         obs_gap  [3][$];

   // expectations for the scenario in progress
   logic [7:0] exp_byte [$];
   logic [2:0] exp_addr [$];
   int         exp_gap  [$];

   always #5 clk = ~clk;

   uart_tx_ram #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .START_ADDR(3'd0)) dut_single (
      .clk(clk), .rst(rst), .start(start[0]), .ram_rdata(rdata[0]), .ram_raddr(raddr[0]),
      .ram_re(ram_re[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
   uart_tx_ram #(.CLKS_PER_BIT(CPB), .NUM_BYTES(8), .START_ADDR(3'd0)) dut_burst (
      .clk(clk), .rst(rst), .start(start[1]), .ram_rdata(rdata[1]), .ram_raddr(raddr[1]),
      .ram_re(ram_re[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
   uart_tx_ram #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4), .START_ADDR(3'd6)) dut_wrap (
      .clk(clk), .rst(rst), .start(start[2]), .ram_rdata(rdata[2]), .ram_raddr(raddr[2]),
      .ram_re(ram_re[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

   // 1-cycle-latency RAM models
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ram_re[k]) rdata[k] <= mem[k][raddr[k]];
      end
   end

   // Frame decoder: offset 0 is the first low sample; bits sampled mid-bit.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            in_frame[k] = 1'b0;
            ones[k]     = 99;
         end else begin
            if (ram_re[k]) obs_addr[k].push_back(raddr[k]);
            if (done[k]) done_cnt[k]++;
            if (!in_frame[k]) begin
               if (tx[k] == 1'b0) begin
                  in_frame[k] = 1'b1;
                  off[k]      = 0;
                  if (ones[k] <= 8) obs_gap[k].push_back(ones[k]);
               end else if (ones[k] < 99) begin
                  ones[k]++;
               end
            end else begin
               off[k]++;
               if (off[k] >= 6 && off[k] <= 34 && ((off[k] - 6) % 4) == 0)
                  sh[k][(off[k] - 6) / 4] = tx[k];
               if (off[k] == 38) stopv[k] = tx[k];
               if (off[k] == 39) begin
                  obs_byte[k].push_back(sh[k]);
                  obs_stop[k].push_back(stopv[k]);
                  in_frame[k] = 1'b0;
                  ones[k]     = 0;
               end
            end
         end
      end
   end

   task automatic test_reset();
      logic [2:0] exp_ra [3];
      bit         bad;
      exp_ra = '{3'd0, 3'd0, 3'd6};
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 || ram_re[k] !== 1'b0 || raddr[k] !== exp_ra[k]) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: tx=%b busy=%b done=%b re=%b raddr=%0d, want 1 0 0 0 %0d",
                     k, tx[k], busy[k], done[k], ram_re[k], raddr[k], exp_ra[k]);
         end
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (tx[1] !== 1'b0 || busy[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_pre_midframe: tx=%b busy=%b, want 0 1", tx[1], busy[1]);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (tx[1] !== 1'b1 || busy[1] !== 1'b0 || done[1] !== 1'b0 || ram_re[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_midframe: tx=%b busy=%b done=%b re=%b, want 1 0 0 0", tx[1], busy[1], done[1], ram_re[1]);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (tx[1] !== 1'b1 || busy[1] !== 1'b0 || done[1] !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL reset_quiet_after: activity seen after abort, want tx=1 busy=0 done=0");
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] ref_b, ob, eb;
      logic [2:0] oa, ea;
      logic       etx, ebusy, edone, ere;
      int         d0;
      ref_b = mem[0][0];
      obs_byte[0].delete(); obs_stop[0].delete(); obs_addr[0].delete();
      exp_byte.push_back(ref_b);
      exp_addr.push_back(3'd0);
      d0 = done_cnt[0];
      start[0] = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 44; k++) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (k <= 2)       etx = 1'b1;
         else if (k <= 6)  etx = 1'b0;
         else if (k <= 38) etx = ref_b[(k - 7) / 4];
         else              etx = 1'b1;
         ebusy = (k <= 42);
         edone = (k == 43);
         ere   = (k == 0);
         n_cmp++;
         if (tx[0] !== etx || busy[0] !== ebusy || done[0] !== edone || ram_re[0] !== ere) begin
            n_bad++;
            $display("FAIL single_wave cyc%0d: tx=%b busy=%b done=%b re=%b, want %b %b %b %b",
                     k, tx[0], busy[0], done[0], ram_re[0], etx, ebusy, edone, ere);
         end
         if (k == 0) begin
            n_cmp++;
            if (raddr[0] !== 3'd0) begin
               n_bad++;
               $display("FAIL single_raddr: got %0d want 0", raddr[0]);
            end
         end
      end
      n_cmp++;
      if (obs_byte[0].size() != 1 || obs_addr[0].size() != 1) begin
         n_bad++;
         $display("FAIL single_count: frames=%0d reads=%0d, want 1 1", obs_byte[0].size(), obs_addr[0].size());
      end
      if (obs_byte[0].size() > 0) begin
         ob = obs_byte[0].pop_front(); eb = exp_byte.pop_front();
         n_cmp++;
         if (ob !== eb) begin n_bad++; $display("FAIL single_byte: got %h want %h", ob, eb); end
      end
      if (obs_addr[0].size() > 0) begin
         oa = obs_addr[0].pop_front(); ea = exp_addr.pop_front();
         n_cmp++;
         if (oa !== ea) begin n_bad++; $display("FAIL single_addr: got %0d want %0d", oa, ea); end
      end
      n_cmp++;
      if (done_cnt[0] - d0 != 1) begin
         n_bad++;
         $display("FAIL single_done_count: got %0d want 1", done_cnt[0] - d0);
      end
      exp_byte.delete(); exp_addr.delete();
   endtask

   task automatic test_full_burst();
      logic [7:0] ob, eb;
      logic [2:0] oa, ea;
      logic       os;
      int         og, eg, d0;
      bit         got;
      obs_byte[1].delete(); obs_stop[1].delete(); obs_addr[1].delete(); obs_gap[1].delete();
      for (int i = 0; i < 8; i++) begin
         exp_byte.push_back(mem[1][i]);
         exp_addr.push_back(3'(i));
         if (i > 0) exp_gap.push_back(3);
      end
      d0 = done_cnt[1];
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 1000 && !got; c++) begin
         @(negedge clk);
         if (done[1]) got = 1'b1;
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL burst_timeout: done=0 after 1000 cycles, want done pulse"); end
      repeat (20) @(negedge clk);
      n_cmp++;
      if (obs_byte[1].size() != exp_byte.size() || obs_addr[1].size() != exp_addr.size()) begin
         n_bad++;
         $display("FAIL burst_count: frames=%0d reads=%0d, want %0d %0d",
                  obs_byte[1].size(), obs_addr[1].size(), exp_byte.size(), exp_addr.size());
      end
      while (exp_byte.size() > 0 && obs_byte[1].size() > 0) begin
         eb = exp_byte.pop_front(); ob = obs_byte[1].pop_front(); os = obs_stop[1].pop_front();
         n_cmp++;
         if (ob !== eb || os !== 1'b1) begin n_bad++; $display("FAIL burst_byte: got %h stop %b want %h stop 1", ob, os, eb); end
      end
      while (exp_addr.size() > 0 && obs_addr[1].size() > 0) begin
         ea = exp_addr.pop_front(); oa = obs_addr[1].pop_front();
         n_cmp++;
         if (oa !== ea) begin n_bad++; $display("FAIL burst_addr: got %0d want %0d", oa, ea); end
      end
      n_cmp++;
      if (obs_gap[1].size() != exp_gap.size()) begin
         n_bad++;
         $display("FAIL burst_gap_count: got %0d want %0d", obs_gap[1].size(), exp_gap.size());
      end
      while (exp_gap.size() > 0 && obs_gap[1].size() > 0) begin
         eg = exp_gap.pop_front(); og = obs_gap[1].pop_front();
         n_cmp++;
         if (og != eg) begin n_bad++; $display("FAIL burst_gap: got %0d want %0d", og, eg); end
      end
      n_cmp++;
      if (done_cnt[1] - d0 != 1) begin n_bad++; $display("FAIL burst_done_count: got %0d want 1", done_cnt[1] - d0); end
      exp_byte.delete(); exp_addr.delete(); exp_gap.delete();
   endtask

   task automatic test_wrap();
      logic [7:0] ob, eb;
      logic [2:0] oa, ea, a;
      int         og, eg, d0;
      bit         got;
      obs_byte[2].delete(); obs_stop[2].delete(); obs_addr[2].delete(); obs_gap[2].delete();
      a = 3'd6;
      for (int i = 0; i < 4; i++) begin
         exp_byte.push_back(mem[2][a]);
         exp_addr.push_back(a);
         if (i > 0) exp_gap.push_back(3);
         a = a + 3'd1;
      end
      d0 = done_cnt[2];
      start[2] = 1'b1;
      @(negedge clk);
      start[2] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 600 && !got; c++) begin
         @(negedge clk);
         if (done[2]) got = 1'b1;
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL wrap_timeout: done=0 after 600 cycles, want done pulse"); end
      repeat (20) @(negedge clk);
      n_cmp++;
      if (obs_byte[2].size() != 4 || obs_addr[2].size() != 4 || obs_gap[2].size() != 3) begin
         n_bad++;
         $display("FAIL wrap_count: frames=%0d reads=%0d gaps=%0d, want 4 4 3",
                  obs_byte[2].size(), obs_addr[2].size(), obs_gap[2].size());
      end
      while (exp_addr.size() > 0 && obs_addr[2].size() > 0) begin
         ea = exp_addr.pop_front(); oa = obs_addr[2].pop_front();
         n_cmp++;
         if (oa !== ea) begin n_bad++; $display("FAIL wrap_addr: got %0d want %0d", oa, ea); end
      end
      while (exp_byte.size() > 0 && obs_byte[2].size() > 0) begin
         eb = exp_byte.pop_front(); ob = obs_byte[2].pop_front();
         n_cmp++;
         if (ob !== eb) begin n_bad++; $display("FAIL wrap_byte: got %h want %h", ob, eb); end
      end
      while (exp_gap.size() > 0 && obs_gap[2].size() > 0) begin
         eg = exp_gap.pop_front(); og = obs_gap[2].pop_front();
         n_cmp++;
         if (og != eg) begin n_bad++; $display("FAIL wrap_gap: got %0d want %0d", og, eg); end
      end
      n_cmp++;
      if (done_cnt[2] - d0 != 1) begin n_bad++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt[2] - d0); end
      exp_byte.delete(); exp_addr.delete(); exp_gap.delete();
   endtask

   task automatic test_start_while_busy();
      logic [7:0] ob, eb;
      int         d0;
      bit         got;
      obs_byte[1].delete(); obs_stop[1].delete(); obs_addr[1].delete(); obs_gap[1].delete();
      for (int i = 0; i < 8; i++) exp_byte.push_back(mem[1][i]);
      d0 = done_cnt[1];
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (obs_byte[1].size() >= 1) got = 1'b1;
      end
      repeat (10) @(negedge clk);
      n_cmp++;
      if (!got || busy[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_during_frame2: first_frame=%b busy=%b, want 1 1", got, busy[1]);
      end
      start[1] = 1'b1;
      repeat (2) @(negedge clk);
      start[1] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 1000 && !got; c++) begin
         @(negedge clk);
         if (done[1]) got = 1'b1;
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL ignore_timeout: done=0 after 1000 cycles, want done pulse"); end
      repeat (150) @(negedge clk);
      n_cmp++;
      if (obs_byte[1].size() != 8 || obs_addr[1].size() != 8 || done_cnt[1] - d0 != 1) begin
         n_bad++;
         $display("FAIL ignore_count: frames=%0d reads=%0d dones=%0d, want 8 8 1",
                  obs_byte[1].size(), obs_addr[1].size(), done_cnt[1] - d0);
      end
      while (exp_byte.size() > 0 && obs_byte[1].size() > 0) begin
         eb = exp_byte.pop_front(); ob = obs_byte[1].pop_front();
         n_cmp++;
         if (ob !== eb) begin n_bad++; $display("FAIL ignore_byte: got %h want %h", ob, eb); end
      end
      exp_byte.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] ob, eb;
      logic [2:0] oa, ea;
      int         og, eg, nd;
      obs_byte[1].delete(); obs_stop[1].delete(); obs_addr[1].delete(); obs_gap[1].delete();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 8; i++) begin
            exp_byte.push_back(mem[1][i]);
            exp_addr.push_back(3'(i));
            if (i > 0) exp_gap.push_back(3);
            else if (b > 0) exp_gap.push_back(4);
         end
      end
      start[1] = 1'b1;
      nd = 0;
      for (int c = 0; c < 2000 && nd < 2; c++) begin
         @(negedge clk);
         if (done[1]) nd++;
      end
      start[1] = 1'b0;
      n_cmp++;
      if (nd != 2) begin n_bad++; $display("FAIL b2b_timeout: dones=%0d after 2000 cycles, want 2", nd); end
      repeat (60) @(negedge clk);
      n_cmp++;
      if (obs_byte[1].size() != 16 || obs_addr[1].size() != 16 || obs_gap[1].size() != 15) begin
         n_bad++;
         $display("FAIL b2b_count: frames=%0d reads=%0d gaps=%0d, want 16 16 15",
                  obs_byte[1].size(), obs_addr[1].size(), obs_gap[1].size());
      end
      while (exp_byte.size() > 0 && obs_byte[1].size() > 0) begin
         eb = exp_byte.pop_front(); ob = obs_byte[1].pop_front();
         n_cmp++;
         if (ob !== eb) begin n_bad++; $display("FAIL b2b_byte: got %h want %h", ob, eb); end
      end
      while (exp_addr.size() > 0 && obs_addr[1].size() > 0) begin
         ea = exp_addr.pop_front(); oa = obs_addr[1].pop_front();
         n_cmp++;
         if (oa !== ea) begin n_bad++; $display("FAIL b2b_addr: got %0d want %0d", oa, ea); end
      end
      while (exp_gap.size() > 0 && obs_gap[1].size() > 0) begin
         eg = exp_gap.pop_front(); og = obs_gap[1].pop_front();
         n_cmp++;
         if (og != eg) begin n_bad++; $display("FAIL b2b_gap: got %0d want %0d", og, eg); end
      end
      exp_byte.delete(); exp_addr.delete(); exp_gap.delete();
   endtask

   initial begin
      rst   = 1'b1;
      start = '0;
      for (int i = 0; i < 8; i++) begin
         mem[0][i] = 8'(8'hF0 + i);
         mem[1][i] = 8'(8'h30 + i);
         mem[2][i] = 8'(8'h51 + 3 * i);
      end
      mem[0][0] = 8'hA5;
      test_reset();
      test_single_byte();
      test_full_burst();
      test_wrap();
      test_start_while_busy();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at 1 ms, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
